// File: rtl/up_timer_if.sv
// Signal bundle for up_timer: count/control pulses in, BCD digits and status out.
// The master side drives the control pulses; the slave side is the timer itself.
interface up_timer_if;
    logic       tick;
    logic       start_stop;
    logic       clr;
    logic [3:0] sec_lo;
    logic [3:0] sec_hi;
    logic [3:0] min_lo;
    logic [3:0] min_hi;
    logic       running;
    logic       full;
    logic       cout;

    modport master (
        output tick,
        output start_stop,
        output clr,
        input  sec_lo,
        input  sec_hi,
        input  min_lo,
        input  min_hi,
        input  running,
        input  full,
        input  cout
    );

    modport slave (
        input  tick,
        input  start_stop,
        input  clr,
        output sec_lo,
        output sec_hi,
        output min_lo,
        output min_hi,
        output running,
        output full,
        output cout
    );
endinterface

// File: rtl/up_timer.sv
// MM:SS BCD up-timer with run/pause control; at full scale it either holds (FULL state)
// or rolls over to 00:00 with a one-cycle carry-out pulse.
module up_timer #(
    parameter int unsigned MAXMIN = 59,
    parameter int unsigned WRAP   = 0
) (
    input  logic      clk,
    input  logic      reset,
    up_timer_if.slave bus
);

    localparam logic [3:0] MAX_MIN_HI = 4'(MAXMIN / 10);
    localparam logic [3:0] MAX_MIN_LO = 4'(MAXMIN % 10);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StPause,
        StFull
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] sec_lo_q, sec_lo_d;
    logic [3:0] sec_hi_q, sec_hi_d;
    logic [3:0] min_lo_q, min_lo_d;
    logic [3:0] min_hi_q, min_hi_d;
    logic       running_q, full_q, cout_q, cout_d;
    logic       at_full;

    assign at_full = (sec_lo_q == 4'd9) && (sec_hi_q == 4'd5) &&
                     (min_lo_q == MAX_MIN_LO) && (min_hi_q == MAX_MIN_HI);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            sec_lo_q  <= 4'd0;
            sec_hi_q  <= 4'd0;
            min_lo_q  <= 4'd0;
            min_hi_q  <= 4'd0;
            running_q <= 1'b0;
            full_q    <= 1'b0;
            cout_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sec_lo_q  <= sec_lo_d;
            sec_hi_q  <= sec_hi_d;
            min_lo_q  <= min_lo_d;
            min_hi_q  <= min_hi_d;
            running_q <= (state_d == StRun);
            full_q    <= (state_d == StFull);
            cout_q    <= cout_d;
        end
    end

    // Priority: clr, then start_stop, then tick.
    always_comb begin
        state_d  = state_q;
        sec_lo_d = sec_lo_q;
        sec_hi_d = sec_hi_q;
        min_lo_d = min_lo_q;
        min_hi_d = min_hi_q;
        cout_d   = 1'b0;

        if (bus.clr) begin
            state_d  = StIdle;
            sec_lo_d = 4'd0;
            sec_hi_d = 4'd0;
            min_lo_d = 4'd0;
            min_hi_d = 4'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.start_stop) state_d = StRun;
                end
                StRun: begin
                    if (bus.start_stop) begin
                        state_d = StPause;
                    end else if (bus.tick) begin
                        if (at_full) begin
                            if (WRAP != 0) begin
                                sec_lo_d = 4'd0;
                                sec_hi_d = 4'd0;
                                min_lo_d = 4'd0;
                                min_hi_d = 4'd0;
                                cout_d   = 1'b1;
                            end else begin
                                state_d = StFull;
                            end
                        end else if (sec_lo_q != 4'd9) begin
                            sec_lo_d = sec_lo_q + 4'd1;
                        end else begin
                            sec_lo_d = 4'd0;
                            if (sec_hi_q != 4'd5) begin
                                sec_hi_d = sec_hi_q + 4'd1;
                            end else begin
                                sec_hi_d = 4'd0;
                                // Below full scale the minute pair can never pass MAXMIN.
                                if (min_lo_q != 4'd9) begin
                                    min_lo_d = min_lo_q + 4'd1;
                                end else begin
                                    min_lo_d = 4'd0;
                                    min_hi_d = min_hi_q + 4'd1;
                                end
                            end
                        end
                    end
                end
                StPause: begin
                    if (bus.start_stop) state_d = StRun;
                end
                StFull: begin
                    state_d = StFull;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    assign bus.sec_lo  = sec_lo_q;
    assign bus.sec_hi  = sec_hi_q;
    assign bus.min_lo  = min_lo_q;
    assign bus.min_hi  = min_hi_q;
    assign bus.running = running_q;
    assign bus.full    = full_q;
    assign bus.cout    = cout_q;

endmodule

// File: tb/tb_up_timer.sv
// Scoreboard bench for up_timer: a hold-at-full and a wrapping instance share stimulus;
// an integer-seconds model pushes expectations that are popped after each clock edge.
module tb_up_timer;

    localparam int FULL_SECS = 59 * 60 + 59;

    typedef struct {
        int inst;
        int secs;
        int st;     // 0 idle, 1 run, 2 pause, 3 full
        bit cout;
    } exp_t;

    logic clk;
    logic rst_n;

    up_timer_if b0 ();
    up_timer_if b1 ();

    up_timer #(.MAXMIN(59), .WRAP(0)) dut0 (.clk(clk), .reset(rst_n), .bus(b0));
    up_timer #(.MAXMIN(59), .WRAP(1)) dut1 (.clk(clk), .reset(rst_n), .bus(b1));

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];
    int   m_secs[2];
    int   m_st[2];
    bit   m_cout[2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int secs);
        int m;
        int s;
        m = secs / 60;
        s = secs % 60;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_secs[i] = 0;
            m_st[i]   = 0;
            m_cout[i] = 1'b0;
        end
    endfunction

    function automatic void model_step(input int i, input bit t, input bit s, input bit c);
        m_cout[i] = 1'b0;
        if (c) begin
            m_secs[i] = 0;
            m_st[i]   = 0;
        end else begin
            case (m_st[i])
                0: if (s) m_st[i] = 1;
                1: begin
                    if (s) begin
                        m_st[i] = 2;
                    end else if (t) begin
                        if (m_secs[i] == FULL_SECS) begin
                            if (i == 1) begin
                                m_secs[i] = 0;
                                m_cout[i] = 1'b1;
                            end else begin
                                m_st[i] = 3;
                            end
                        end else begin
                            m_secs[i]++;
                        end
                    end
                end
                2: if (s) m_st[i] = 1;
                default: ;
            endcase
        end
    endfunction

    function automatic void push_expect();
        for (int i = 0; i < 2; i++) begin
            sb.push_back('{inst: i, secs: m_secs[i], st: m_st[i], cout: m_cout[i]});
        end
    endfunction

    task automatic drain();
        exp_t        e;
        logic [15:0] dg;
        logic        r;
        logic        f;
        logic        c;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.inst == 0) begin
                dg = {b0.min_hi, b0.min_lo, b0.sec_hi, b0.sec_lo};
                r  = b0.running;
                f  = b0.full;
                c  = b0.cout;
            end else begin
                dg = {b1.min_hi, b1.min_lo, b1.sec_hi, b1.sec_lo};
                r  = b1.running;
                f  = b1.full;
                c  = b1.cout;
            end
            check_val($sformatf("d%0d.digits@%0t", e.inst, $time), 32'(dg), 32'(to_bcd(e.secs)));
            check_val($sformatf("d%0d.running@%0t", e.inst, $time), 32'(r), 32'(e.st == 1));
            check_val($sformatf("d%0d.full@%0t", e.inst, $time), 32'(f), 32'(e.st == 3));
            check_val($sformatf("d%0d.cout@%0t", e.inst, $time), 32'(c), 32'(e.cout));
        end
    endtask

    // Drive one cycle of inputs at the falling edge, compare just after the rising edge.
    task automatic step(input bit t, input bit s, input bit c);
        @(negedge clk);
        b0.tick = t;  b0.start_stop = s;  b0.clr = c;
        b1.tick = t;  b1.start_stop = s;  b1.clr = c;
        for (int i = 0; i < 2; i++) model_step(i, t, s, c);
        push_expect();
        @(posedge clk);
        #1;
        drain();
    endtask

    initial begin
        rst_n = 1'b0;
        b0.tick = 1'b0;  b0.start_stop = 1'b0;  b0.clr = 1'b0;
        b1.tick = 1'b0;  b1.start_stop = 1'b0;  b1.clr = 1'b0;
        model_reset();
        #3;
        push_expect();
        drain();
        @(negedge clk);
        rst_n = 1'b1;

        // Tick in IDLE is ignored; start, then 10 ticks -> 00:10.
        step(1, 0, 0);
        step(0, 1, 0);
        repeat (10) step(1, 0, 0);
        step(0, 0, 0);

        // Start+tick in IDLE enters RUN without counting; stop+tick in RUN pauses at 00:05.
        step(0, 0, 1);
        step(1, 1, 0);
        repeat (5) step(1, 0, 0);
        step(1, 1, 0);
        repeat (3) step(1, 0, 0);
        step(0, 1, 0);

        // Count through 00:59, 09:59 and up to 59:59.
        while (m_secs[0] != FULL_SECS) step(1, 0, 0);
        step(1, 0, 0);
        step(1, 0, 0);
        step(0, 1, 0);
        step(1, 1, 0);
        step(1, 0, 0);
        step(0, 0, 1);

        // Run to 12:34 then pulse reset between clock edges.
        step(0, 1, 0);
        repeat (12 * 60 + 34) step(1, 0, 0);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        push_expect();
        drain();
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 0, 0);
        step(0, 1, 0);
        step(1, 0, 0);
        step(1, 0, 0);

        // clr beats simultaneous start_stop and tick.
        step(1, 1, 1);
        step(0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
